// File: rtl/huff_enc_ctrl_if.sv
// Character stream, encoder load/result and job status signals of huff_enc_ctrl.
interface huff_enc_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        in_last;
  logic        enc_reset;
  logic [11:0] enc_io_in;
  logic [11:0] enc_io_out;
  logic        res_valid;
  logic [11:0] res_data;
  logic [1:0]  res_status;
  logic        busy;

  modport master (
    output in_valid, in_char, in_last, enc_io_out,
    input  in_ready, enc_reset, enc_io_in, res_valid, res_data, res_status, busy
  );

  modport slave (
    input  in_valid, in_char, in_last, enc_io_out,
    output in_ready, enc_reset, enc_io_in, res_valid, res_data, res_status, busy
  );
endinterface

// File: rtl/huff_enc_ctrl.sv
// Job controller for huff_encoder: counts character frequencies, loads the encoder,
// waits for done (with timeout) and reports the result with a status code.
module huff_enc_ctrl #(
  parameter int unsigned MAX_CHAR_COUNT = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic            clk,
  input logic            reset,
  huff_enc_ctrl_if.slave ctrl
);
  localparam int unsigned N  = MAX_CHAR_COUNT;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + N) + 1;

  typedef enum logic [2:0] {IDLE, COUNT, ENC_RST, LOAD, WAIT, DONE} state_t;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_OVF = 2'b01, ST_TIMEOUT = 2'b10} status_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          cnt_clr;

  logic [N-1:0]  slot_valid;
  logic [7:0]    slot_char [N];
  logic [2:0]    slot_cnt  [N];
  logic          ovf;

  logic          ready;
  logic          accept;
  logic [N-1:0]  hit_vec;
  logic [N-1:0]  alloc_vec;
  logic          alloc_found;
  logic          ovf_now;
  logic          done_seen;
  logic          timeout_hit;
  logic [11:0]   beat;

  logic          res_load;
  logic [11:0]   res_data_next;
  status_t       res_status_next;
  logic [11:0]   res_data_q;
  status_t       res_status_q;

  assign ready       = !reset && (state == IDLE || state == COUNT);
  assign accept      = ctrl.in_valid && ready;
  assign done_seen   = ctrl.enc_io_out[8];
  assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Slots fill in order and are only cleared together, so the valid slots form a prefix.
  always_comb begin
    hit_vec     = '0;
    alloc_vec   = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      hit_vec[i] = slot_valid[i] && (slot_char[i] == ctrl.in_char);
      if (!slot_valid[i] && !alloc_found) begin
        alloc_vec[i] = 1'b1;
        alloc_found  = 1'b1;
      end
    end
  end

  // Overflow caused by the final character must already steer the last-accept decision.
  assign ovf_now = ovf || (accept && (hit_vec == '0) && !alloc_found);

  always_comb begin
    beat = 12'h800;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt == CW'(i) && slot_valid[i]) begin
        beat = {1'b1, slot_cnt[i], slot_char[i]};
      end
    end
  end

  always_comb begin
    state_next      = state;
    cnt_clr         = 1'b0;
    res_load        = 1'b0;
    res_data_next   = '0;
    res_status_next = ST_OK;
    case (state)
      IDLE, COUNT: begin
        if (accept) begin
          if (ctrl.in_last) begin
            if (ovf_now) begin
              state_next      = DONE;
              res_load        = 1'b1;
              res_status_next = ST_OVF;
            end else begin
              state_next = ENC_RST;
            end
          end else begin
            state_next = COUNT;
          end
        end
      end
      ENC_RST: begin
        state_next = LOAD;
        cnt_clr    = 1'b1;
      end
      LOAD: begin
        if (cnt == CW'(N - 1)) begin
          state_next = WAIT;
          cnt_clr    = 1'b1;
        end
      end
      WAIT: begin
        if (done_seen) begin
          state_next    = DONE;
          res_load      = 1'b1;
          res_data_next = ctrl.enc_io_out;
        end else if (timeout_hit) begin
          state_next      = DONE;
          res_load        = 1'b1;
          res_status_next = ST_TIMEOUT;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      res_data_q   <= '0;
      res_status_q <= ST_OK;
    end else begin
      state <= state_next;
      cnt   <= cnt_clr ? '0 : cnt + CW'(1);
      if (res_load) begin
        res_data_q   <= res_data_next;
        res_status_q <= res_status_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state == DONE) begin
      slot_valid <= '0;
      ovf        <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        slot_char[i] <= '0;
        slot_cnt[i]  <= '0;
      end
    end else if (accept) begin
      if (hit_vec != '0) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (hit_vec[i] && slot_cnt[i] != 3'd7) begin
            slot_cnt[i] <= slot_cnt[i] + 3'd1;
          end
        end
      end else if (alloc_found) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (alloc_vec[i]) begin
            slot_valid[i] <= 1'b1;
            slot_char[i]  <= ctrl.in_char;
            slot_cnt[i]   <= 3'd1;
          end
        end
      end else begin
        ovf <= 1'b1;
      end
    end
  end

  assign ctrl.in_ready   = ready;
  assign ctrl.enc_reset  = reset || (state == ENC_RST);
  assign ctrl.enc_io_in  = (!reset && state == LOAD) ? beat : '0;
  assign ctrl.res_valid  = !reset && (state == DONE);
  assign ctrl.res_data   = res_data_q;
  assign ctrl.res_status = res_status_q;
  assign ctrl.busy       = !reset && !(state == IDLE || state == COUNT);
endmodule

// File: doc/huff_enc_ctrl.md
Name: huff_enc_ctrl

Overview:
Job controller in front of huff_encoder. It accepts a raw character stream and builds a per-character frequency table. It then resets the encoder, loads it with exactly MAX_CHAR_COUNT beats of {valid, freq, char} on the encoder's 12-bit io_in, waits for the encoder's done flag, and returns the encoder result with a status code. Overflow of the distinct-character table and encoder hang (timeout) are detected and reported instead of stalling.

Parameters:
MAX_CHAR_COUNT, 3, number of table slots and number of load beats per job (must match the encoder build).
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before a timeout is declared (>=2).

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  input character valid.
in_ready  out  1  controller can accept a character.
in_char  in  8  input character (ASCII).
in_last  in  1  marks the final character of the message; qualified by in_valid&in_ready.
enc_reset  out  1  reset to huff_encoder.
enc_io_in  out  12  encoder io_in: [11] valid, [10:8] freq, [7:0] char.
enc_io_out  in  12  encoder io_out; bit [8] = done.
res_valid  out  1  one-cycle result strobe.
res_data  out  12  captured enc_io_out (0 on error).
res_status  out  2  00 ok, 01 table overflow, 10 timeout; valid with res_valid.
busy  out  1  high in every state except IDLE and COUNT.

Behaviour:
- Reset values: in_ready=0 during reset, 1 afterwards (IDLE). enc_reset=1 while reset is high. enc_io_in=0, res_valid=0, res_data=0, res_status=00, busy=0. Table is cleared and overflow flag is 0.
- States: IDLE, COUNT, ENC_RST, LOAD, WAIT, DONE.
- in_ready=1 only in IDLE and COUNT. An accept is in_valid&in_ready.
- Accept in IDLE -> COUNT. An accept with in_last in IDLE or COUNT -> ENC_RST (same char is counted first). If the overflow flag is set (including by that last char), go to DONE with status 01 instead.
- Table update per accept:
  - A char matching a valid slot increments that slot's count, saturating at 7.
  - Otherwise the char allocates the lowest free slot with count 1.
  - With no free slot, the overflow flag is set and the table is unchanged.
  - Slots keep allocation order.
- ENC_RST: exactly 1 cycle. enc_reset=1, enc_io_in=0.
- LOAD: exactly MAX_CHAR_COUNT cycles. Beat k drives {1, cnt[k], char[k]} for valid slots and pad {1, 3'd0, 8'h00} for empty slots. enc_io_in=0 in all other states.
- WAIT:
  - A cycle counter starts at 0 on entry.
  - enc_io_out[8] sampled high -> DONE, capturing res_data=enc_io_out, status 00.
  - Counter reaching TIMEOUT_CYCLES-1 without done -> DONE, status 10, res_data=0.
  - Done has priority over timeout on the same cycle.
  - enc_io_out[8] is ignored outside WAIT.
- DONE: 1 cycle. res_valid=1, res_data and res_status driven. Table and flag are cleared. Next state is IDLE. res_data/res_status hold their value until the next DONE.
- Latency:
  - Last char accepted at cycle t: enc_reset high at t+1, LOAD beats at t+2..t+1+N (N = MAX_CHAR_COUNT), WAIT entered at t+2+N.
  - Done seen at cycle w: res_valid at w+1.
  - Timeout: res_valid TIMEOUT_CYCLES cycles after WAIT entry.
  - Overflow: res_valid at t+1, with no enc_reset pulse and no load beats.
- Reset mid-operation, any state: next cycle is IDLE, the table is cleared, and no res_valid is produced for the aborted job.
- No job queueing: while busy, in_ready=0, so no characters are consumed.

Test Plan:
- Stream 7×'~', 6×'|', 7×'}' interleaved, last on the final '}'; encoder model raises done 5 cycles into WAIT with io_out=0x1A5 -> one enc_reset pulse; beats 0xF7E, 0xE7C, 0xF7D; res_valid with res_data=0x1A5, status 00, exactly 1 cycle after done.
- 9×'a' with last -> beats 0xF61, 0x800, 0x800 (count saturated at 7, two pads); job completes normally.
- Chars 'a','b','c','d' with last on 'd' -> no enc_reset pulse, no beats; res_valid next cycle with status 01, res_data=0; in_ready returns next cycle.
- Encoder model never raises done -> res_valid with status 10 exactly 64 cycles after WAIT entry; next job accepted afterwards and completes with status 00.
- Reset asserted during the 2nd LOAD beat -> enc_io_in=0 and enc_reset=1 during reset, IDLE afterwards, no res_valid; a following 'x'×2 job loads beat 0xA78.
- Hold in_valid high continuously across a job -> in_ready=0 from ENC_RST through DONE; no characters dropped or double-counted; busy matches ~in_ready outside reset.
